// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encodings and datapath widths.
package muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration on {acc, q}: a right-shifting shift-add step
// for multiply, or a left-shifting restoring subtract step for divide.
module muldiv_iter_step #(
    parameter int W = 32
) (
    input  logic         is_div,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] q_o
);

    logic [W-1:0] addend;
    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W-1:0] diff;

    always_comb begin
        addend  = q_i[0] ? b_i : '0;
        sum     = {1'b0, acc_i} + {1'b0, addend};
        shifted = {acc_i, q_i[W-1]};
        // The restored remainder is always below the divisor, so W bits suffice.
        diff    = shifted[W-1:0] - b_i;
        if (is_div) begin
            if (shifted >= {1'b0, b_i}) begin
                acc_o = diff;
                q_o   = {q_i[W-2:0], 1'b1};
            end else begin
                acc_o = shifted[W-1:0];
                q_o   = {q_i[W-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[W:1];
            q_o   = {sum[0], q_i[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide
// iterations on operand magnitudes, followed by a sign-fix/word-select cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] step_acc, step_q;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] fix_result;

    muldiv_iter_step #(.W(XLEN)) u_step (
        .is_div (op_q[2]),
        .acc_i  (acc_q),
        .q_i    (q_q),
        .b_i    (b_q),
        .acc_o  (step_acc),
        .q_o    (step_q)
    );

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed && rs1[XLEN-1];
        b_neg    = b_signed && rs2[XLEN-1];
        a_mag    = a_neg ? -rs1 : rs1;
        b_mag    = b_neg ? -rs2 : rs2;
        div_zero = op[2] && (rs2 == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MOST_NEG) && (rs2 == '1);
    end

    always_comb begin
        prod     = {acc_q, q_q};
        prod_fix = neg_q ? -prod : prod;
        if (!op_q[2]) begin
            fix_result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            fix_result = neg_q ? -q_q : q_q;
        end else begin
            fix_result = rem_neg_q ? -acc_q : acc_q;
        end
    end

    // Special cases preload {acc, q} with the final answer and clear the sign
    // flags, so FIX passes them through unchanged.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        acc_d     = acc_q;
        q_d       = q_q;
        b_d       = b_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d = ST_IDLE;
                    if (start) begin
                        op_d      = op;
                        count_d   = '1;
                        acc_d     = '0;
                        q_d       = a_mag;
                        b_d       = b_mag;
                        neg_d     = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                        state_d   = ST_CALC;
                        if (div_zero) begin
                            acc_d     = rs1;
                            q_d       = '1;
                            neg_d     = 1'b0;
                            rem_neg_d = 1'b0;
                            state_d   = ST_FIX;
                        end else if (div_ovf) begin
                            q_d       = MOST_NEG;
                            neg_d     = 1'b0;
                            rem_neg_d = 1'b0;
                            state_d   = ST_FIX;
                        end
                    end
                end
                ST_CALC: begin
                    acc_d = step_acc;
                    q_d   = step_q;
                    if (count_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                ST_FIX: begin
                    result_d = fix_result;
                    state_d  = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors push expected
// results and done-edge numbers; a monitor pops and checks on every done pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        string       name;
        logic [31:0] exp_val;
        int          exp_edge;
    } sb_entry_t;

    sb_entry_t sb[$];
    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge (edge cyc+1).
    task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp,
                                 input bit special, input bit track);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        if (track) sb.push_back('{name, exp, cyc + 1 + (special ? 1 : 33)});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, output int busy_cycles);
        int n = 0;
        busy_cycles = 0;
        while (!done && n < 80) begin
            if (busy) busy_cycles++;
            n++;
            @(negedge clk);
        end
        checkOutput({name, "_done_seen"}, {31'b0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit special);
        int bc;
        applyStimulus(name, o, a, b, exp, special, 1'b1);
        waitDone(name, bc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_done: got done=1 with result 0x%08h, expected no done (cycle %0d)", result, cyc);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                checkOutput(e.name, result, e.exp_val);
                checkOutput({e.name, "_latency_edge"}, cyc, e.exp_edge);
            end
        end
    end

    initial begin
        int bc;
        int n;
        int done_cnt;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1);
        waitDone("mul_7_m3", bc);
        checkOutput("mul_busy_cycles", bc, 32'd33);

        runOp("mulh_min_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        runOp("mulhu_ff_ff",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        runOp("mulhsu_ff_ff",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp("div_m7_2",       OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        runOp("rem_m7_2",       OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
        runOp("divu_100_7",     OP_DIVU,   32'd100,       32'd7,         32'd14,        1'b0);
        runOp("remu_100_7",     OP_REMU,   32'd100,       32'd7,         32'd2,         1'b0);
        runOp("divu_5_0",       OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
        runOp("div_ovf",        OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        runOp("rem_ovf",        OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
        runOp("rem_5_0",        OP_REM,    32'd5,         32'd0,         32'd5,         1'b1);

        // start pulse during CALC must be ignored
        applyStimulus("divu_1000_7", OP_DIVU, 32'd1000, 32'd7, 32'd142, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = OP_MUL;
        rs1   = 32'd3;
        rs2   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        checkOutput("result_held_in_calc", result, 32'd5);
        waitDone("divu_1000_7", bc);

        // flush at cycle 10 of a divide: no done, result kept
        applyStimulus("div_flushed", OP_DIV, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {31'b0, busy}, 32'd0);
        checkOutput("flush_done", {31'b0, done}, 32'd0);
        checkOutput("flush_result_kept", result, 32'd142);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        checkOutput("flush_no_done_pulse", done_cnt, 32'd0);

        runOp("mulhu_after_flush", OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0);

        // start held high through DONE: next op is accepted from DONE
        start = 1'b1;
        op    = OP_MUL;
        rs1   = 32'd6;
        rs2   = 32'd7;
        sb.push_back('{"mul_6_7_held", 32'd42, cyc + 1 + 33});
        @(negedge clk);
        n = 0;
        while (!done && n < 80) begin
            n++;
            @(negedge clk);
        end
        checkOutput("held_first_done_seen", {31'b0, done}, 32'd1);
        op  = OP_REMU;
        rs1 = 32'd100;
        rs2 = 32'd7;
        sb.push_back('{"remu_from_done", 32'd2, cyc + 1 + 33});
        @(negedge clk);
        start = 1'b0;
        waitDone("remu_from_done", bc);

        // reset at cycle 5 of a divide
        applyStimulus("div_reset", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midop_reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("midop_reset_done", {31'b0, done}, 32'd0);
        checkOutput("midop_reset_result", result, 32'd0);
        runOp("div_after_reset", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit for the single-cycle core. It takes rs1/rs2 and funct3 when the decoder flags an M-extension instruction, and runs a multi-cycle shift-add or restoring-divide sequence. Its result drives the M-extension input of the 16:1 32-bit writeback/result select mux. The core stalls PC and register-file write while start=1 and done=0.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 5, iteration-counter width, equal to log2(XLEN).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
start  input  1  request new operation; sampled only in IDLE or DONE
flush  input  1  abort the current operation (pipeline kill/trap)
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  32  operand A / dividend; captured at start
rs2  input  32  operand B / divisor; captured at start
busy  output  1  high in CALC and FIX states
done  output  1  high for exactly one cycle (DONE state)
result  output  32  registered result; held until next accepted start

Behaviour:
- Reset: clk edge with rst_n=0 gives state=IDLE, busy=0, done=0, result=0, and clears all internal registers. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE (2-bit encoding).
- IDLE/DONE + start=1: capture op and operand magnitudes, then go to CALC with count=31. If the op is special, go to FIX instead.
- DONE + start=0: go to IDLE. done stays high for 1 cycle only.
- CALC: one iteration per edge. At count=0, go to FIX; otherwise decrement count.
- FIX: apply sign correction and select the high or low word, write result, then go to DONE.
- Latency: for start sampled at edge N, done is high in the cycle after edge N+33 for normal ops and after edge N+1 for special cases.
- busy is high from after edge N until DONE is entered.
- start while busy is ignored. Operands and op are never re-sampled mid-operation.
- flush=1 in any state goes to IDLE next edge, with busy=0 and done=0. result keeps its previous value. flush has priority over start.
- Multiply:
  - Magnitudes are unsigned: rs1 signed for MULH/MULHSU; rs2 signed for MULH only.
  - Product is a 64-bit shift-add. It is negated in FIX if the operand signs differ.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - Restoring algorithm on magnitudes (signed for DIV/REM).
  - Quotient is negated if the signs differ. Remainder takes the dividend's sign.
- Special cases, detected at start, skip CALC:
  - Divide by zero (rs2=0): quotient is 0xFFFFFFFF; remainder is rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF): quotient is 0x80000000; remainder is 0.
- No exceptions are raised; all arithmetic is modulo 2^32 / 2^64 as described.

Decomposition:
- Shared header: funct3 op encodings (OP_MUL..OP_REMU), state encodings, and XLEN.
- One natural sub-module, muldiv_iter_step. It is combinational, performing one shift-add or one restore/subtract step on the {acc, q} registers. It is instantiated once and selected by an is_div flag.
- The FSM, counter, sign fix and special-case logic stay in muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD: busy high 33 cycles; done after edge N+33; result=0xFFFFFFEB.
- High-word multiplies:
  - MULH 0x80000000×0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9/2 gives 0xFFFFFFFD; REM same operands gives 0xFFFFFFFF.
  - DIVU 100/7 gives 14; REMU gives 2.
- Special cases:
  - DIVU 5/0 gives 0xFFFFFFFF with done after edge N+1.
  - REM 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM gives 0.
- Handshake:
  - start pulses during CALC are ignored (result unchanged until done).
  - flush at cycle 10 gives busy=0 next cycle and no done pulse.
  - A new MULHU then completes with the correct value.
  - start held high in DONE is accepted and starts the next op.
- Reset: rst_n=0 for one edge at cycle 5 of a DIV gives busy=0, done=0, result=0 next cycle; a subsequent op is correct.
